// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle sequencer and the MIPS datapath.
// The master (sequencer) reads the opcode and memory handshake and drives every strobe and mux select.
interface multicycle_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluOp;
  logic [1:0] PCSource;

  modport master (
    input  op, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource
  );

  modport slave (
    output op, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, AluSrcA, AluSrcB, AluOp, PCSource
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared memory,
// waits on mem_ready, and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  multicycle_control_if.master bus,
  output logic [3:0]           state,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_RD    = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WR    = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11,
    HALT      = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic             retire;

  // Raw per-state control values before enable/reset gating
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_source;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= FETCH;
      count_reg <= '0;
    end else if (en) begin
      state_reg <= state_next;
      if (retire) begin
        count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 3'b000;
    pc_source     = 2'b00;

    case (state_reg)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end
      DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        alu_src_b = 2'b11;
        case (bus.op)
          OP_LW, OP_SW: state_next = MEM_ADDR;
          OP_R:         state_next = R_EXEC;
          OP_BEQ:       state_next = BRANCH;
          OP_J:         state_next = JUMP;
          OP_ADDI:      state_next = ADDI_EXEC;
          default:      state_next = HALT;
        endcase
      end
      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (bus.op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (bus.mem_ready) begin
          state_next = MEM_WB;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        state_next = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 3'b001;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_next    = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        retire     = 1'b1;
        state_next = FETCH;
      end
      ADDI_EXEC: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_next = FETCH;
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = HALT;
      end
    endcase
  end

  // Strobes die when frozen or in reset; selects only die in reset
  logic strobe_ok;
  logic run_ok;

  assign run_ok    = ~rst;
  assign strobe_ok = en & ~rst;

  assign bus.PCWrite     = pc_write      & strobe_ok;
  assign bus.PCWriteCond = pc_write_cond & strobe_ok;
  assign bus.MemRead     = mem_read      & strobe_ok;
  assign bus.MemWrite    = mem_write     & strobe_ok;
  assign bus.IRWrite     = ir_write      & strobe_ok;
  assign bus.RegWrite    = reg_write     & strobe_ok;
  assign bus.IorD        = iord          & run_ok;
  assign bus.MemToReg    = mem_to_reg    & run_ok;
  assign bus.RegDst      = reg_dst       & run_ok;
  assign bus.AluSrcA     = alu_src_a     & run_ok;
  assign bus.AluSrcB     = alu_src_b     & {2{run_ok}};
  assign bus.AluOp       = alu_op        & {3{run_ok}};
  assign bus.PCSource    = pc_source     & {2{run_ok}};

  assign state       = state_reg;
  assign halted      = (state_reg == HALT) & run_ok;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes its expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b1;
  logic [3:0]       state;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;

  multicycle_control_if bus ();

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus.master),
    .state       (state),
    .halted      (halted),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic        hlt;
    int          cnt;
  } exp_t;

  exp_t sb[$];

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, ILL = 6'b111111;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] dut_ctrl();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemToReg, bus.RegDst, bus.RegWrite, bus.AluSrcA, bus.AluSrcB, bus.AluOp, bus.PCSource};
  endfunction

  // Control table straight from the state descriptions
  function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input bit run);
    logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rd = 0, rw = 0, sa = 0;
    logic [1:0] sbv = 0, ps = 0;
    logic [2:0] ao = 0;
    case (st)
      0:  begin mr = 1; sbv = 2'b01; if (rdy) begin irw = 1; pcw = 1; end end
      1:  sbv = 2'b11;
      2:  begin sa = 1; sbv = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; iord = 1; end
      6:  begin sa = 1; ao = 3'b010; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 3'b001; pcwc = 1; ps = 2'b01; end
      9:  begin pcw = 1; ps = 2'b10; end
      10: begin sa = 1; sbv = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    if (!run) begin
      pcw = 0; pcwc = 0; irw = 0; rw = 0; mr = 0; mw = 0;
    end
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sbv, ao, ps};
  endfunction

  // One clock of stimulus plus its expected outputs; retire bumps the model count after this cycle
  task automatic cyc(input bit run, input logic [5:0] opc, input bit rdy, input int st, input bit retire);
    exp_t e;
    @(negedge clk);
    rst = 1'b0;
    en = run;
    bus.op = opc;
    bus.mem_ready = rdy;
    e.st = st[3:0];
    e.ctrl = exp_ctrl(st, rdy, run);
    e.hlt = (st == 12);
    e.cnt = exp_cnt;
    sb.push_back(e);
    if (retire) exp_cnt++;
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic rst_pulse(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check({tag, "_state"}, {28'd0, state}, 32'd0);
    check({tag, "_ctrl"}, {15'd0, dut_ctrl()}, 32'd0);
    check({tag, "_cnt"}, instr_count, 32'd0);
    exp_cnt = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("state", {28'd0, state}, {28'd0, e.st});
        check("ctrl", {15'd0, dut_ctrl()}, {15'd0, e.ctrl});
        check("halted", {31'd0, halted}, {31'd0, e.hlt});
        check("count", instr_count, e.cnt);
        $display("txn st=%0d ctrl=%05h halted=%0b cnt=%0d", state, dut_ctrl(), halted, instr_count);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bus.op = RT;
    bus.mem_ready = 1'b1;
    en = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctrl", {15'd0, dut_ctrl()}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt", instr_count, 32'd0);

    // lw: 0,1,2,3,4 ; op noise in FETCH is ignored
    cyc(1, ILL, 1, 0, 0);
    cyc(1, LW, 1, 1, 0);
    cyc(1, LW, 1, 2, 0);
    cyc(1, ILL, 1, 3, 0);
    cyc(1, JMP, 1, 4, 1);
    // sw with three wait cycles in MEM_WR; op changes ignored there
    cyc(1, SW, 1, 0, 0);
    cyc(1, SW, 1, 1, 0);
    cyc(1, SW, 1, 2, 0);
    cyc(1, LW, 0, 5, 0);
    cyc(1, ILL, 0, 5, 0);
    cyc(1, RT, 0, 5, 0);
    cyc(1, SW, 1, 5, 1);
    // R, beq, j back to back
    cyc(1, RT, 1, 0, 0);
    cyc(1, RT, 1, 1, 0);
    cyc(1, RT, 1, 6, 0);
    cyc(1, RT, 1, 7, 1);
    cyc(1, BEQ, 1, 0, 0);
    cyc(1, BEQ, 1, 1, 0);
    cyc(1, BEQ, 1, 8, 1);
    cyc(1, JMP, 1, 0, 0);
    cyc(1, JMP, 1, 1, 0);
    cyc(1, JMP, 1, 9, 1);
    // addi, with a FETCH stall on mem_ready first
    cyc(1, ADDI, 0, 0, 0);
    cyc(1, ADDI, 1, 0, 0);
    cyc(1, ADDI, 1, 1, 0);
    cyc(1, ADDI, 1, 10, 0);
    cyc(1, ADDI, 1, 11, 1);
    // R with en=0 frozen in FETCH and then R_EXEC
    cyc(0, RT, 1, 0, 0);
    cyc(1, RT, 1, 0, 0);
    cyc(1, RT, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, RT, 1, 6, 0);
    cyc(1, RT, 1, 6, 0);
    cyc(1, RT, 1, 7, 1);
    // lw stalled in MEM_RD, then async reset between edges
    cyc(1, LW, 1, 0, 0);
    cyc(1, LW, 1, 1, 0);
    cyc(1, LW, 1, 2, 0);
    cyc(1, LW, 0, 3, 0);
    cyc(1, LW, 0, 3, 0);
    rst_pulse("rst_memrd");
    // illegal opcode halts
    cyc(1, ILL, 1, 0, 0);
    cyc(1, ILL, 1, 1, 0);
    for (int i = 0; i < 11; i++) cyc(1, (i % 2 == 0) ? LW : RT, 1, 12, 0);
    rst_pulse("rst_halt");
    cyc(1, JMP, 1, 0, 0);
    cyc(1, JMP, 1, 1, 0);
    cyc(1, JMP, 1, 9, 1);
    cyc(1, JMP, 0, 0, 0);

    @(negedge clk);
    #3;
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multicycle version of the MIPS datapath over one shared instruction/data memory.
- Datapath storage it drives: PC, IR, register bank, ALU, ALU-control, memory.
- Replaces the single-cycle combinational control unit.
- Issues per-state control strobes, waits on a memory ready handshake, retires one instruction per pass back to FETCH, and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter instr_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run enable; low freezes FSM and counter.
- op  input  6  IR[31:26] opcode, valid from DECODE onward.
- mem_ready  input  1  memory completes current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if ALU Zflag=1 (beq).
- IorD  output  1  memory address select: 0=PC, 1=ALU out register.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  instruction register load.
- MemToReg  output  1  register write data: 1=memory data register, 0=ALU out.
- RegDst  output  1  write address: 1=IR[15:11], 0=IR[20:16].
- RegWrite  output  1  register bank write.
- AluSrcA  output  1  0=PC, 1=register A.
- AluSrcB  output  2  00=register B, 01=const 4, 10=sign-extend, 11=sign-extend<<2.
- AluOp  output  3  000=add, 001=sub, 010=use funct; others unused.
- PCSource  output  2  00=ALU result, 01=ALU out register, 10=jump target.
- state  output  4  current state encoding (debug).
- halted  output  1  high in HALT.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010; any other is illegal.
- States and encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11, HALT=12.
  - Encodings 13-15 are unreachable; if entered, go to HALT.
- Reset: while rst=1 (async), state=FETCH, instr_count=0, and every control output, including MemRead, is 0. FETCH outputs begin the first cycle after rst deasserts.
- Enable: en=0 holds state and instr_count and forces PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite to 0. Mux selects keep their state values.
- Default in every state: all strobes 0, selects 0.
- FETCH: MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, AluOp=000, PCSource=00. If mem_ready, also IRWrite=1 and PCWrite=1 (Mealy) and go to DECODE; otherwise stay.
- DECODE: AluSrcA=0, AluSrcB=11, AluOp=000 (branch target precompute). Next state by op:
  - lw/sw -> MEM_ADDR; R -> R_EXEC; beq -> BRANCH; j -> JUMP; addi -> ADDI_EXEC; illegal -> HALT.
- MEM_ADDR: AluSrcA=1, AluSrcB=10, AluOp=000. Next: lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: MemRead=1, IorD=1; on mem_ready go to MEM_WB, else stay.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0; go to FETCH.
- MEM_WR: MemWrite=1, IorD=1 held until mem_ready; then go to FETCH.
- R_EXEC: AluSrcA=1, AluSrcB=00, AluOp=010; go to R_WB.
- R_WB: RegWrite=1, RegDst=1, MemToReg=0; go to FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, AluOp=001, PCWriteCond=1, PCSource=01; go to FETCH.
- JUMP: PCWrite=1, PCSource=10; go to FETCH.
- ADDI_EXEC: AluSrcA=1, AluSrcB=10, AluOp=000; go to ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemToReg=0; go to FETCH.
- HALT: all strobes 0, halted=1; stays until rst.
- Cycle counts with mem_ready=1 every cycle: lw=5; sw=4; R=4; addi=4; beq=3; j=3.
- Retirement: instr_count increments by 1 on each clock edge where state leaves MEM_WB, MEM_WR (on mem_ready), R_WB, BRANCH, JUMP or ADDI_WB. It wraps modulo 2^CNT_W. HALT entry does not count.
- op is sampled only in DECODE and MEM_ADDR; changes elsewhere are ignored.
- Reset mid-instruction aborts immediately, including during memory wait states; no partial strobes after rst asserts.

Test Plan:
- Reset: rst=1 with en=1, mem_ready=1 -> all outputs 0, state=0. Release rst -> next cycle MemRead=1, IorD=0, AluSrcB=01, IRWrite=1, PCWrite=1.
- lw, op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. RegWrite=1 with MemToReg=1 only in state 4. instr_count 0->1.
- Memory wait: sw with mem_ready low for 3 cycles in MEM_WR -> MemWrite=1 and IorD=1 for 4 cycles, then FETCH. instr_count increments once.
- R-type, beq and j, back-to-back, mem_ready=1 -> 4+3+3 cycles:
  - R_WB: RegDst=1.
  - BRANCH: PCWriteCond=1, AluOp=001, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - instr_count=3.
- Illegal op=111111 in DECODE -> state=12, halted=1, strobes 0 for 10+ cycles. instr_count unchanged. rst recovers to FETCH.
- en=0 for 5 cycles in R_EXEC -> state stays 6, all strobes 0. Resumes to R_WB when en=1. Async rst pulse mid-MEM_RD (between edges) -> state=0 immediately.
